// File: rtl/btn_updown_counter.sv
// Button-driven up/down decimal counter (0..9999).
// Three raw buttons (run/stop, clear, up/down) are synchronized, debounced
// and edge-detected into single-cycle pulses that drive a STOP/RUN/CLEAR
// FSM. In RUN a tick divider produces one count step every TICK_DIV cycles.

// Synchronizer + debouncer + rising-edge detector for one raw button.
module btn_conditioner #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] stable_cnt;
  logic          level;
  logic          level_q;

  // Two-flop synchronizer; sync[1] is the first safe copy of the button.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], btn_raw};
  end

  // Debounce: adopt the synchronized value only once it has disagreed with
  // the current level for DB_CYCLES consecutive cycles; any agreement
  // restarts the count, so short glitches never reach the level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (sync[1] == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == DB_MAX) begin
      level      <= sync[1];
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

  // Registered rising-edge detector: one pulse per press, none on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// Top level: button conditioning, control FSM, tick divider and counter.
module btn_updown_counter #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_clear,
  input  logic        btn_mode,
  output logic [13:0] count,
  output logic        running,
  output logic        dir_down
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [13:0]      COUNT_MAX = 14'd9999;

  logic             run_pulse;
  logic             clear_pulse;
  logic             mode_pulse;
  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_run (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_run),
    .pulse   (run_pulse)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clear (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_clear),
    .pulse   (clear_pulse)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_mode (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_mode),
    .pulse   (mode_pulse)
  );

  // A step is due on the last cycle of each divider period, only in RUN.
  assign tick = (state == ST_RUN) && (div_cnt == DIV_LAST);

  // Next-state logic; clear has priority over run, CLEAR lasts one cycle.
  // NOTE: state_next gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_next = state;
    if (state == ST_CLEAR) begin
      state_next = ST_STOP;
    end else if (clear_pulse) begin
      state_next = ST_CLEAR;
    end else begin
      unique case (state)
        ST_STOP: if (run_pulse) state_next = ST_RUN;
        ST_RUN:  if (run_pulse) state_next = ST_STOP;
        default: state_next = ST_STOP;
      endcase
    end
  end

  // State register; running is registered alongside so it mirrors RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_STOP;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == ST_RUN);
    end
  end

  // Tick divider: advances only in RUN, holds in STOP so a restart resumes
  // the partial period, and is zeroed by CLEAR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      div_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Counter with decimal wrap in both directions; the >= guard keeps the
  // value in range even if it were ever corrupted above 9999.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (state == ST_CLEAR) begin
      count <= '0;
    end else if (tick) begin
      if (dir_down) count <= (count == 14'd0 || count > COUNT_MAX) ? COUNT_MAX : count - 14'd1;
      else          count <= (count >= COUNT_MAX) ? 14'd0 : count + 14'd1;
    end
  end

  // Direction toggle; a tick on the same edge still sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           dir_down <= 1'b0;
    else if (mode_pulse) dir_down <= ~dir_down;
  end

endmodule

// File: tb/tb_btn_updown_counter.sv
// Directed testbench for btn_updown_counter with TICK_DIV=4, DB_CYCLES=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too (or at the falling edge for the range monitor).
module tb_btn_updown_counter;

  logic        clk;
  logic        reset;
  logic        btn_run;
  logic        btn_clear;
  logic        btn_mode;
  logic [13:0] count;
  logic        running;
  logic        dir_down;

  int errors = 0;
  int checks = 0;

  btn_updown_counter #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_run   (btn_run),
    .btn_clear (btn_clear),
    .btn_mode  (btn_mode),
    .count     (count),
    .running   (running),
    .dir_down  (dir_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        clear;
    logic        mode;
    int          adv;
    logic [13:0] exp_count;
    logic        exp_running;
    logic        exp_dir;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_run   = 1'b0;
    btn_clear = 1'b0;
    btn_mode  = 1'b0;
    reset     = 1'b1;
    step(3);
    check("rst_count", 32'(count), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_dir", 32'(dir_down), 32'd0);
    reset = 1'b0;
  endtask

  // Bounded wait for the next count change; returns cycles waited.
  task automatic wait_change(input int limit, output int cycles);
    logic [13:0] prev;
    prev   = count;
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (count == prev && cycles < limit);
    if (count == prev) begin
      errors++;
      checks++;
      $display("FAIL wait_change: count stuck at %0d after %0d cycles", count, cycles);
    end
  endtask

  // Range monitor: the count must never exceed 9999.
  always @(negedge clk) begin
    if (!reset) check("count_range", 32'(count <= 14'd9999), 32'd1);
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;

    // Rows: {run, clear, mode, cycles to advance, count, running, dir_down}.
    vecs[0]  = '{1'b1, 1'b0, 1'b0,  7, 14'd0,    1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0,  1, 14'd0,    1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0,  3, 14'd0,    1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0,  1, 14'd1,    1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0,  4, 14'd2,    1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0,  4, 14'd3,    1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0,  4, 14'd4,    1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 12, 14'd7,    1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1,  8, 14'd9,    1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0,  4, 14'd8,    1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0,  8, 14'd6,    1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0,  7, 14'd5,    1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0,  1, 14'd4,    1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0,  1, 14'd0,    1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 10, 14'd0,    1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b0,  8, 14'd0,    1'b1, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0,  4, 14'd9999, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b0,  4, 14'd9998, 1'b1, 1'b1};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      btn_run   = vecs[i].run;
      btn_clear = vecs[i].clear;
      btn_mode  = vecs[i].mode;
      step(vecs[i].adv);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].exp_running));
      check($sformatf("vec%0d_dir", i), 32'(dir_down), 32'(vecs[i].exp_dir));
    end

    // Glitchy run button: 2 high, 1 low, 2 high -> no pulse.
    do_reset();
    btn_run = 1'b1; step(2);
    btn_run = 1'b0; step(1);
    btn_run = 1'b1; step(2);
    btn_run = 1'b0; step(20);
    check("glitch_running", 32'(running), 32'd0);
    check("glitch_count", 32'(count), 32'd0);

    // Mode then run: count down wraps 0 -> 9999 -> 9998, then up across 9999.
    do_reset();
    btn_mode = 1'b1; step(8);
    btn_mode = 1'b0; step(10);
    check("down_dir", 32'(dir_down), 32'd1);
    check("down_idle_running", 32'(running), 32'd0);
    btn_run = 1'b1; step(8);
    btn_run = 1'b0;
    check("down_running", 32'(running), 32'd1);
    wait_change(20, cyc);
    check("down_first", 32'(count), 32'd9999);
    wait_change(20, cyc);
    check("down_second", 32'(count), 32'd9998);
    check("down_period", 32'(cyc), 32'd4);
    btn_mode = 1'b1;
    wait_change(20, cyc);
    check("down_third", 32'(count), 32'd9997);
    wait_change(20, cyc);
    btn_mode = 1'b0;
    check("coincide_old_dir", 32'(count), 32'd9996);
    check("coincide_dir_now_up", 32'(dir_down), 32'd0);
    wait_change(20, cyc);
    check("up_9997", 32'(count), 32'd9997);
    wait_change(20, cyc);
    check("up_9998", 32'(count), 32'd9998);
    wait_change(20, cyc);
    check("up_9999", 32'(count), 32'd9999);
    wait_change(20, cyc);
    check("up_wrap_0", 32'(count), 32'd0);

    // Turn direction down again, then reset mid-period.
    btn_mode = 1'b1;
    wait_change(20, cyc);
    check("pre_rst_1", 32'(count), 32'd1);
    wait_change(20, cyc);
    btn_mode = 1'b0;
    check("pre_rst_2", 32'(count), 32'd2);
    check("pre_rst_dir", 32'(dir_down), 32'd1);
    step(2);
    reset = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_running", 32'(running), 32'd0);
    check("async_rst_dir", 32'(dir_down), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(20);
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_running", 32'(running), 32'd0);

    // Run held through reset release counts as a fresh press.
    reset   = 1'b1;
    btn_run = 1'b1;
    step(3);
    reset = 1'b0;
    step(7);
    check("held_rst_not_yet", 32'(running), 32'd0);
    step(1);
    check("held_rst_running", 32'(running), 32'd1);
    btn_run = 1'b0;
    wait_change(20, cyc);
    check("held_rst_count", 32'(count), 32'd1);

    // Run and clear on the same cycle: clear wins, then STOP at zero.
    btn_run   = 1'b1;
    btn_clear = 1'b1;
    step(8);
    check("both_running", 32'(running), 32'd0);
    step(1);
    check("both_count", 32'(count), 32'd0);
    check("both_running_after", 32'(running), 32'd0);
    btn_run   = 1'b0;
    btn_clear = 1'b0;
    step(20);
    check("both_stays_stopped", 32'(running), 32'd0);
    check("both_stays_zero", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
